// File: rtl/codec_pkg.sv
// Shared types and defaults for the codec serial-port slave model.
package codec_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 16;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    // LRCLK level selects the slot: 0 = left, 1 = right
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        DATA,
        PAD
    } state_t;

endpackage

// File: rtl/codec_model_if.sv
// Serial pins plus the parallel sample ports of the codec model.
interface codec_model_if
    import codec_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             SCLK;
    logic             LRCLK;
    logic             SD_in;
    logic             RST_n;
    logic             SD_out;
    logic [WIDTH-1:0] adc_left;
    logic [WIDTH-1:0] adc_right;
    logic             adc_req;
    logic [WIDTH-1:0] dac_left;
    logic [WIDTH-1:0] dac_right;
    logic             dac_valid;

    // Interface side: drives the pins and the ADC samples
    modport master (
        output SCLK, LRCLK, SD_in, RST_n, adc_left, adc_right,
        input  SD_out, adc_req, dac_left, dac_right, dac_valid
    );

    // Codec side: consumes the pins, returns serial and parallel data
    modport slave (
        input  SCLK, LRCLK, SD_in, RST_n, adc_left, adc_right,
        output SD_out, adc_req, dac_left, dac_right, dac_valid
    );

endinterface

// File: rtl/codec_model_edge_sync.sv
// Multi-flop synchroniser with single-clk rise/fall pulses on the synced level.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q      = sync_q[SYNC_STAGES-1];
    assign rise_c = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/codec_model.sv
// Slave-side I2S codec model: serialises ADC words, deserialises DAC words.
module codec_model
    import codec_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    codec_model_if.slave bus
);

    localparam int unsigned CNT_W   = $clog2(WIDTH + 2);
    localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);

    logic sclk_rise_c, sclk_fall_c;
    logic lr_s, sd_s, rst_s;
    logic unused_sclk_s;
    logic unused_lr_rise_c, unused_lr_fall_c;
    logic unused_sd_rise_c, unused_sd_fall_c;
    logic unused_rst_rise_c, unused_rst_fall_c;

    state_t               state_q, state_d;
    chan_t                chan_q, chan_d;
    logic                 lr_prev_q, lr_prev_d;
    logic                 primed_q, primed_d;
    logic [PRIME_W-1:0]   prime_cnt_q, prime_cnt_d;
    logic [WIDTH-1:0]     tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [WIDTH-2:0]     rx_sh_q, rx_sh_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [WIDTH-1:0]     shadow_r_q, shadow_r_d;
    logic                 sd_out_q, sd_out_d;
    logic                 adc_req_q, adc_req_d;
    logic [WIDTH-1:0]     dac_left_q, dac_left_d;
    logic [WIDTH-1:0]     dac_right_q, dac_right_d;
    logic                 dac_valid_q, dac_valid_d;
    logic                 boundary_c;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d(bus.SCLK),
        .q(unused_sclk_s), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
        .clk(clk), .rst_n(rst_n), .d(bus.LRCLK),
        .q(lr_s), .rise_c(unused_lr_rise_c), .fall_c(unused_lr_fall_c)
    );
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sd_sync (
        .clk(clk), .rst_n(rst_n), .d(bus.SD_in),
        .q(sd_s), .rise_c(unused_sd_rise_c), .fall_c(unused_sd_fall_c)
    );
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
        .clk(clk), .rst_n(rst_n), .d(bus.RST_n),
        .q(rst_s), .rise_c(unused_rst_rise_c), .fall_c(unused_rst_fall_c)
    );

    // A slot boundary is an LRCLK change between consecutive SCLK falls
    assign boundary_c = primed_q && sclk_fall_c && (lr_s != lr_prev_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: codec reset/priming forces IDLE, any boundary restarts a slot
    always_comb begin
        state_d = state_q;
        if (!rst_s || !primed_q) begin
            state_d = IDLE;
        end else if (boundary_c) begin
            state_d = DELAY;
        end else begin
            case (state_q)
                DELAY:   state_d = DATA;
                DATA:    if (sclk_fall_c && tx_cnt_q == CNT_W'(WIDTH)) state_d = PAD;
                default: state_d = state_q;
            endcase
        end
    end

    // Output/datapath next values
    always_comb begin
        lr_prev_d   = lr_prev_q;
        primed_d    = primed_q;
        prime_cnt_d = prime_cnt_q;
        chan_d      = chan_q;
        tx_sh_d     = tx_sh_q;
        tx_cnt_d    = tx_cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_cnt_d    = rx_cnt_q;
        shadow_r_d  = shadow_r_q;
        sd_out_d    = sd_out_q;
        adc_req_d   = 1'b0;
        dac_left_d  = dac_left_q;
        dac_right_d = dac_right_q;
        dac_valid_d = 1'b0;

        // Track LRCLK while the sync chain fills so startup sees no false boundary
        if (!primed_q) begin
            prime_cnt_d = prime_cnt_q + 1'b1;
            primed_d    = (prime_cnt_q == PRIME_W'(SYNC_STAGES));
            lr_prev_d   = lr_s;
        end else if (sclk_fall_c) begin
            lr_prev_d = lr_s;
        end

        if (!rst_s || !primed_q) begin
            sd_out_d = 1'b0;
            tx_cnt_d = '0;
            rx_cnt_d = '0;
        end else if (boundary_c) begin
            // The tx register doubles as the left shadow; right is held for its slot
            chan_d   = chan_t'(lr_s);
            sd_out_d = 1'b0;
            tx_cnt_d = '0;
            rx_cnt_d = '0;
            if (chan_t'(lr_s) == LEFT) begin
                tx_sh_d    = bus.adc_left;
                shadow_r_d = bus.adc_right;
                adc_req_d  = 1'b1;
            end else begin
                tx_sh_d = shadow_r_q;
            end
        end else begin
            case (state_q)
                DATA: begin
                    // LSB is held for a full bit period; the fall after it ends the word
                    if (sclk_fall_c) begin
                        if (tx_cnt_q < CNT_W'(WIDTH)) begin
                            sd_out_d = tx_sh_q[WIDTH-1];
                            tx_sh_d  = tx_sh_q << 1;
                            tx_cnt_d = tx_cnt_q + 1'b1;
                        end else begin
                            sd_out_d = 1'b0;
                        end
                    end
                    // First rise after the boundary is the I2S delay bit
                    if (sclk_rise_c) begin
                        if (rx_cnt_q <= CNT_W'(WIDTH)) begin
                            rx_cnt_d = rx_cnt_q + 1'b1;
                        end
                        if (rx_cnt_q != '0 && rx_cnt_q <= CNT_W'(WIDTH)) begin
                            rx_sh_d = {rx_sh_q[WIDTH-3:0], sd_s};
                            if (rx_cnt_q == CNT_W'(WIDTH)) begin
                                if (chan_q == RIGHT) begin
                                    dac_right_d = {rx_sh_q, sd_s};
                                    dac_valid_d = 1'b1;
                                end else begin
                                    dac_left_d = {rx_sh_q, sd_s};
                                end
                            end
                        end
                    end
                end
                IDLE, PAD: sd_out_d = 1'b0;
                default:   sd_out_d = sd_out_q;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_prev_q   <= 1'b0;
            primed_q    <= 1'b0;
            prime_cnt_q <= '0;
            chan_q      <= LEFT;
            tx_sh_q     <= '0;
            tx_cnt_q    <= '0;
            rx_sh_q     <= '0;
            rx_cnt_q    <= '0;
            shadow_r_q  <= '0;
            sd_out_q    <= 1'b0;
            adc_req_q   <= 1'b0;
            dac_left_q  <= '0;
            dac_right_q <= '0;
            dac_valid_q <= 1'b0;
        end else begin
            lr_prev_q   <= lr_prev_d;
            primed_q    <= primed_d;
            prime_cnt_q <= prime_cnt_d;
            chan_q      <= chan_d;
            tx_sh_q     <= tx_sh_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_cnt_q    <= rx_cnt_d;
            shadow_r_q  <= shadow_r_d;
            sd_out_q    <= sd_out_d;
            adc_req_q   <= adc_req_d;
            dac_left_q  <= dac_left_d;
            dac_right_q <= dac_right_d;
            dac_valid_q <= dac_valid_d;
        end
    end

    assign bus.SD_out    = sd_out_q;
    assign bus.adc_req   = adc_req_q;
    assign bus.dac_left  = dac_left_q;
    assign bus.dac_right = dac_right_q;
    assign bus.dac_valid = dac_valid_q;

endmodule

// File: tb/tb_codec_model.sv
// Self-checking bench for codec_model: slot-level reference model of the I2S link.
module tb_codec_model;
    import codec_pkg::*;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    codec_model_if #(.WIDTH(W)) bus ();

    codec_model #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           req_seen   = 0;
    int           valid_seen = 0;
    int           exp_req    = 0;
    int           exp_valid  = 0;
    logic [W-1:0] lat_l  = '0;
    logic [W-1:0] lat_r  = '0;
    logic [W-1:0] exp_dl = '0;
    logic [W-1:0] exp_dr = '0;
    bit           run    = 1'b0;

    // Count clks on which each pulse output is not low
    always @(negedge clk) begin
        if (bus.adc_req !== 1'b0)   req_seen++;
        if (bus.dac_valid !== 1'b0) valid_seen++;
    end

    // One slot of n SCLK periods; period 0 begins at the fall that sets LRCLK=lr
    task automatic slot(input logic lr, input int n, input logic [W-1:0] din,
                        input int hold_k, input int rel_k,
                        input int chg_k, input logic [W-1:0] chg_l);
        logic [W-1:0] word;
        logic         exp_bit;
        logic         din_bit;
        bit           full;
        if (lr != bus.LRCLK && bus.RST_n) begin
            run = 1'b1;
            if (lr == 1'b0) begin
                lat_l = bus.adc_left;
                lat_r = bus.adc_right;
                exp_req++;
            end
        end else if (!bus.RST_n) begin
            run = 1'b0;
        end
        word = lr ? lat_r : lat_l;
        full = run && (n >= int'(W) + 1) && (hold_k < 0 || hold_k >= int'(W) + 1);

        for (int k = 0; k < n; k++) begin
            din_bit = 1'($urandom);
            if (k >= 1 && k <= int'(W)) din_bit = din[int'(W) - k];
            bus.SCLK  = 1'b0;
            bus.LRCLK = lr;
            bus.SD_in = din_bit;
            if (k == hold_k) begin
                bus.RST_n = 1'b0;
                run = 1'b0;
            end
            if (k == rel_k) bus.RST_n = 1'b1;
            if (k == chg_k) bus.adc_left = chg_l;
            repeat (6) @(negedge clk);
            exp_bit = 1'b0;
            if (run && k >= 1 && k <= int'(W)) exp_bit = word[int'(W) - k];
            checks++;
            if (bus.SD_out !== exp_bit) begin
                errors++;
                $display("FAIL sd_out lr=%0b period=%0d got %b want %b", lr, k, bus.SD_out, exp_bit);
            end
            repeat (2) @(negedge clk);
            bus.SCLK = 1'b1;
            repeat (8) @(negedge clk);
        end

        if (full) begin
            if (lr == 1'b0) begin
                exp_dl = din;
            end else begin
                exp_dr = din;
                exp_valid++;
            end
        end
        checks++;
        if (bus.dac_left !== exp_dl) begin
            errors++;
            $display("FAIL dac_left got %h want %h", bus.dac_left, exp_dl);
        end
        checks++;
        if (bus.dac_right !== exp_dr) begin
            errors++;
            $display("FAIL dac_right got %h want %h", bus.dac_right, exp_dr);
        end
        checks++;
        if (req_seen != exp_req) begin
            errors++;
            $display("FAIL adc_req_count got %0d want %0d", req_seen, exp_req);
        end
        checks++;
        if (valid_seen != exp_valid) begin
            errors++;
            $display("FAIL dac_valid_count got %0d want %0d", valid_seen, exp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.SCLK      = 1'b1;
        bus.LRCLK     = 1'b1;
        bus.SD_in     = 1'b0;
        bus.RST_n     = 1'b1;
        bus.adc_left  = 16'h0000;
        bus.adc_right = 16'h0000;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.SD_out !== 1'b0) begin errors++; $display("FAIL reset_sd_out got %b want 0", bus.SD_out); end
        checks++;
        if (bus.adc_req !== 1'b0) begin errors++; $display("FAIL reset_adc_req got %b want 0", bus.adc_req); end
        checks++;
        if (bus.dac_valid !== 1'b0) begin errors++; $display("FAIL reset_dac_valid got %b want 0", bus.dac_valid); end
        checks++;
        if (bus.dac_left !== 16'h0000) begin errors++; $display("FAIL reset_dac_left got %h want 0000", bus.dac_left); end
        checks++;
        if (bus.dac_right !== 16'h0000) begin errors++; $display("FAIL reset_dac_right got %h want 0000", bus.dac_right); end
        bus.adc_left  = 16'h5A5A;
        bus.adc_right = 16'hC3C3;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        // LRCLK stays high: no boundary, so nothing may happen
        slot(1'b1, 32, W'($urandom), -1, -1, -1, '0);
        slot(1'b1, 32, W'($urandom), -1, -1, -1, '0);
    endtask

    task automatic test_loopback();
        bus.adc_left  = 16'hA5C3;
        bus.adc_right = 16'h0F0F;
        for (int f = 0; f < 2; f++) begin
            slot(1'b0, 32, 16'h1234, -1, -1, -1, '0);
            slot(1'b1, 32, 16'hBEEF, -1, -1, -1, '0);
        end
    endtask

    task automatic test_short_slot();
        slot(1'b0, 32, 16'h8001, -1, -1, -1, '0);
        slot(1'b1, 10, 16'h7E7E, -1, -1, -1, '0);
        slot(1'b0, 32, 16'h4321, -1, -1, -1, '0);
        slot(1'b1, 32, 16'hCAFE, -1, -1, -1, '0);
        // One bit short of a full word, then exactly one full word
        slot(1'b0, W, 16'hFFFF, -1, -1, -1, '0);
        slot(1'b1, W + 1, 16'h600D, -1, -1, -1, '0);
    endtask

    task automatic test_rst_hold();
        bus.adc_left  = 16'h1357;
        bus.adc_right = 16'h2468;
        slot(1'b0, 32, 16'hAAAA, 5, -1, -1, '0);
        for (int s = 0; s < 5; s++) begin
            slot(1'(~s[0]), 32, W'($urandom), -1, -1, -1, '0);
        end
        slot(1'b0, 32, 16'h5555, -1, 10, -1, '0);
        slot(1'b1, 32, 16'h0FF0, -1, -1, -1, '0);
        slot(1'b0, 32, 16'h9876, -1, -1, -1, '0);
        slot(1'b1, 32, 16'h3C3C, -1, -1, -1, '0);
    endtask

    task automatic test_adc_change();
        bus.adc_left  = 16'h1111;
        bus.adc_right = 16'h7777;
        slot(1'b0, 32, 16'h0102, -1, -1, -1, '0);
        slot(1'b1, 32, 16'h0304, -1, -1, 8, 16'h2222);
        slot(1'b0, 32, 16'h0506, -1, -1, -1, '0);
        slot(1'b1, 32, 16'h0708, -1, -1, -1, '0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            bus.adc_left  = W'($urandom);
            bus.adc_right = W'($urandom);
            slot(1'b0, int'($urandom_range(12, 40)), W'($urandom), -1, -1, -1, '0);
            slot(1'b1, int'($urandom_range(12, 40)), W'($urandom), -1, -1, -1, '0);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_short_slot();
        test_rst_hold();
        test_adc_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/codec_model.md
Name: codec_model

Overview:
- Synthesizable slave-side model of the audio codec's I2S-style serial port. It is the far end of codec_interface.
- Consumes the SCLK, LRCLK, SD_in and RST_n pins that the interface drives. Serialises ADC sample words onto SD_out. Deserialises DAC words from SD_in.
- Used as a loopback/bring-up partner in FPGA test builds and as a bench responder for codec_interface.

Parameters:
- WIDTH, 16, sample word width in bits (MSB-first).
- SYNC_STAGES, 2, synchroniser depth for SCLK, LRCLK, SD_in and RST_n.

Ports:
- clk  input  1  system clock; all state on posedge clk.
- rst_n  input  1  asynchronous active-low reset.
- SCLK  input  1  bit clock from the interface.
- LRCLK  input  1  word select: 0 = left slot, 1 = right slot.
- SD_in  input  1  serial DAC data from the interface.
- RST_n  input  1  codec reset pin, active low; acts as a synchronous hold.
- adc_left  input  WIDTH  left sample to transmit.
- adc_right  input  WIDTH  right sample to transmit.
- adc_req  output  1  one-clk pulse when both adc words have been latched for the frame.
- SD_out  output  1  serial ADC data to the interface.
- dac_left  output  WIDTH  last complete left word received.
- dac_right  output  WIDTH  last complete right word received.
- dac_valid  output  1  one-clk pulse when dac_right is updated, ending a frame.

Behaviour:
- Reset (rst_n low) values:
  - Outputs: SD_out=0, adc_req=0, dac_valid=0, dac_left=0, dac_right=0.
  - Internal: synchroniser flops=0, state=IDLE, counters=0, primed=0.
- Input synchronisation:
  - SCLK, LRCLK, SD_in and RST_n each pass through SYNC_STAGES flops.
  - Edges of SCLK are detected from the last sync stage against one extra delayed flop.
  - primed sets SYNC_STAGES+1 clks after reset release. No edges are acted on before primed, so no false LRCLK edge occurs at startup.
- Clock-ratio requirement: SCLK high and low times are each >= 6 clk. Below this the behaviour is undefined.
- LRCLK is sampled only on a detected SCLK fall. A slot boundary is an LRCLK value at that fall that differs from the value at the previous fall.
- State machine, per slot:
  - IDLE:
    - Entered when sync RST_n is low or primed=0.
    - SD_out=0, counters cleared, no dac updates.
    - Exits to DELAY on the first slot boundary after RST_n is high.
  - DELAY:
    - Entered at a boundary fall.
    - Boundary into left (LRCLK=0): latch adc_left and adc_right into shadow registers and pulse adc_req in the same clk.
    - Load the tx shift register from the shadow word of the new channel. SD_out=0.
    - Set tx_cnt=0 and rx_cnt=0. Go to DATA.
  - DATA:
    - Each SCLK fall: SD_out takes the shift-register MSB, shift left, tx_cnt+1.
    - Each SCLK rise: if rx_cnt>=1, shift sync SD_in into the rx register. rx_cnt+1 on every rise.
    - Rise 1 after the boundary is the I2S delay bit and is discarded.
    - After WIDTH bits are captured (rise WIDTH+1), write the rx register to dac_left or dac_right according to the slot.
    - A right-slot write pulses dac_valid for 1 clk.
    - After WIDTH bits are transmitted, go to PAD.
  - PAD: SD_out=0 and further SD_in bits are ignored until the next boundary, which goes to DELAY.
- Short slot: a boundary before the WIDTH bits complete aborts the slot. The partial rx word is discarded, dac is not written, dac_valid does not pulse, and a new DELAY starts immediately.
- Latency:
  - SD_out changes SYNC_STAGES+1 clks after the SCLK fall at the pin.
  - dac_* and dac_valid update 1 clk after the completing rise is detected.
- RST_n low mid-slot: go to IDLE in the next clk and drive SD_out=0. dac_* keep their values.
- rst_n low at any time: immediate return to the reset values.
- adc_* inputs only matter at left-boundary latch; changing them mid-frame does not affect the current frame.

Decomposition:
- Package codec_pkg:
  - WIDTH default.
  - typedef enum chan_t {LEFT=0, RIGHT=1}.
  - typedef enum state_t {IDLE, DELAY, DATA, PAD}.
- One sub-module, edge_sync: parameterised SYNC_STAGES synchroniser with rise/fall pulse outputs. Instantiated for SCLK and LRCLK; plain sync-only use for SD_in and RST_n.

Test Plan:
- rst_n low then released, LRCLK held high, SCLK running -> no adc_req, SD_out=0, no dac_valid until the first LRCLK change.
- 32 SCLK per slot, adc_left=16'hA5C3, adc_right=16'h0F0F -> one adc_req per frame. SD_out carries 0, then A5C3 MSB-first, then 15 zeros (left). The right slot repeats the pattern with 0F0F.
- Bench drives SD_in with 16'h1234 (left) and 16'hBEEF (right), each after the delay bit -> dac_left=1234, dac_right=BEEF, one dac_valid after the right LSB rise.
- LRCLK toggles after only 10 SCLK in the right slot -> dac_right unchanged, no dac_valid, next left slot received correctly.
- RST_n driven low mid-left-slot for 3 frames, then high -> SD_out=0 during the hold. Transfer resumes at the first boundary after release with correct data.
- adc_left changed from 1111 to 2222 during the right slot -> 2222 appears only in the following frame's left slot.
